bin_to_bcd_converter: RTL and testbench
=======================================

BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clocks or asynchronous inputs.
REQ-002 Parameter MAX_VALUE, default 9999: largest value representable in four BCD digits, used as the saturation limit.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  synchronous active-high reset.
REQ-005 distance_valid_in  input  1  new binary distance (cm) presented on distance_in this cycle.
REQ-006 distance_in  input  16  unsigned binary distance in cm.
REQ-007 ready_out  output  1  block can accept a new value this cycle.
REQ-008 bcd_out  output  16  four packed BCD digits, [15:12] thousands down to [3:0] ones; feeds the display controller distance input.
REQ-009 bcd_valid_out  output  1  one-cycle pulse when bcd_out has just been updated; drives the display controller trigger input.
REQ-010 overflow_out  output  1  last result was saturated.

Function
REQ-011 States SHALL be IDLE, SHIFT and DONE; ready_out SHALL be 1 only in IDLE (registered, not dependent on distance_valid_in).
REQ-012 Acceptance SHALL occur on a rising edge where state is IDLE and distance_valid_in=1; distance_in is latched on that edge, state goes to SHIFT, iteration counter clears to 0.
REQ-013 On acceptance, if distance_in > MAX_VALUE the latched operand SHALL be MAX_VALUE and a pending-overflow flag set; otherwise operand = distance_in and flag cleared.
REQ-014 Conversion SHALL be iterative double-dabble, one iteration per cycle in SHIFT: every BCD nibble of the 16-bit scratch >= 5 gets +3 (4-bit add, no carry out of the nibble), then {scratch, operand} shifts left by one.
REQ-015 SHIFT SHALL last exactly 16 cycles (counter 0..15); the edge with counter=15 performs the final iteration and transitions to DONE.
REQ-016 On the edge entering DONE, bcd_out SHALL load the final scratch, overflow_out the pending-overflow flag, and bcd_valid_out SHALL go 1.
REQ-017 DONE SHALL last exactly one cycle, then IDLE; bcd_valid_out returns to 0 on that edge.
REQ-018 Latency: bcd_valid_out SHALL be high in the 16th cycle after the acceptance edge; ready_out high again the cycle after; max throughput one conversion per 18 cycles.
REQ-019 distance_valid_in while not IDLE SHALL be ignored and not queued; distance_in changes in SHIFT/DONE SHALL not affect the result.
REQ-020 bcd_out and overflow_out SHALL hold their last value between conversions (display never blanks).
REQ-021 Every bcd_out nibble SHALL always be 0-9; no pattern 0xA-0xF shall ever appear.
REQ-022 Scratch register and counter SHALL be internal and never driven to outputs mid-conversion.

Reset
REQ-023 While rst_in=1 on an edge: state IDLE, ready_out=1, bcd_out=16'h0000, bcd_valid_out=0, overflow_out=0, counter and scratch cleared.
REQ-024 Reset during SHIFT or DONE SHALL abort the conversion with no bcd_valid_out pulse and bcd_out=0; distance_valid_in with rst_in=1 SHALL not be accepted.
REQ-025 First acceptance SHALL be possible on the first edge after rst_in deasserts.

Verification
REQ-026 After reset, distance_in=0, valid one cycle -> 16 cycles later bcd_valid_out=1 for 1 cycle, bcd_out=16'h0000, overflow_out=0.
REQ-027 distance_in=16'd1234 -> bcd_out=16'h1234, overflow_out=0; distance_in=16'd9999 -> 16'h9999, overflow_out=0.
REQ-028 distance_in=16'd10000, then 16'hFFFF -> bcd_out=16'h9999, overflow_out=1 both times; following 16'd42 -> 16'h0042, overflow_out=0.
REQ-029 Accept 16'd57, hold distance_valid_in=1 with distance_in=16'd800 through SHIFT -> one pulse with 16'h0057; 16'd800 accepted only once ready_out returns, giving 16'h0800.
REQ-030 Accept 16'd321, assert rst_in at 8th SHIFT cycle -> no pulse, bcd_out=0, ready_out=1 next cycle; new 16'd5 converts to 16'h0005 normally.
REQ-031 Random sweep 0..65535 vs reference model: every nibble <= 9, exact match/saturation, pulse exactly 1 cycle per acceptance.

Source files
------------

// File: rtl/bin_to_bcd_converter.sv
// Binary-to-BCD converter for the distance display path.
// A 16-bit binary distance is saturated to MAX_VALUE and then converted to
// four packed BCD digits by iterative double-dabble, one bit per cycle.
// The result register holds its value between conversions so the display
// never blanks; bcd_valid_out pulses once per completed conversion.
module bin_to_bcd_converter #(
  parameter int MAX_VALUE = 9999
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        distance_valid_in,
  input  logic [15:0] distance_in,
  output logic        ready_out,
  output logic [15:0] bcd_out,
  output logic        bcd_valid_out,
  output logic        overflow_out
);

  localparam logic [15:0] MAX_V    = 16'(MAX_VALUE);
  localparam logic [3:0]  LAST_ITR = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_scratch;    // BCD accumulator, internal only
  logic [15:0] r_operand;    // binary bits still to be shifted in
  logic [3:0]  r_cnt;        // iteration index within SHIFT
  logic        r_pend_ovf;   // saturation flag for the conversion in flight
  logic        r_ready;
  logic [15:0] r_bcd;
  logic        r_bcd_valid;
  logic        r_ovf;

  logic [15:0] w_adj;        // scratch after the add-3 correction
  logic        w_accept;
  logic        w_last;
  logic [15:0] w_sat;
  logic        w_sat_flag;

  // Add-3 correction: each nibble >= 5 gains 3 so that the following
  // left shift carries correctly into the next decimal digit.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_adj
      always_comb begin
        if (r_scratch[g*4 +: 4] >= 4'd5) w_adj[g*4 +: 4] = r_scratch[g*4 +: 4] + 4'd3;
        else                             w_adj[g*4 +: 4] = r_scratch[g*4 +: 4];
      end
    end
  endgenerate

  // Input saturation and handshake decode.
  always_comb begin
    w_sat_flag = (distance_in > MAX_V);
    w_sat      = w_sat_flag ? MAX_V : distance_in;
    w_accept   = (r_state == S_IDLE) && distance_valid_in;
    w_last     = (r_state == S_SHIFT) && (r_cnt == LAST_ITR);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> SHIFT on accept, SHIFT for 16 cycles, one DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (distance_valid_in) w_next_state = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST_ITR) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: latch/saturate on accept, one double-dabble step per SHIFT cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_scratch  <= 16'h0000;
      r_operand  <= 16'h0000;
      r_cnt      <= 4'd0;
      r_pend_ovf <= 1'b0;
    end else if (w_accept) begin
      r_scratch  <= 16'h0000;
      r_operand  <= w_sat;
      r_cnt      <= 4'd0;
      r_pend_ovf <= w_sat_flag;
    end else if (r_state == S_SHIFT) begin
      {r_scratch, r_operand} <= {w_adj[14:0], r_operand, 1'b0};
      r_cnt                  <= r_cnt + 4'd1;
    end
  end

  // Output registers: result loads on the final iteration and is held afterwards.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_bcd       <= 16'h0000;
      r_ovf       <= 1'b0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= w_last;
      if (w_last) begin
        r_bcd <= {w_adj[14:0], r_operand[15]};
        r_ovf <= r_pend_ovf;
      end
    end
  end

  // Ready is registered from the next state so it never depends on distance_valid_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_ready <= 1'b1;
    else        r_ready <= (w_next_state == S_IDLE);
  end

  assign ready_out     = r_ready;
  assign bcd_out       = r_bcd;
  assign bcd_valid_out = r_bcd_valid;
  assign overflow_out  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter. Expected results come from a
// decimal-arithmetic model; a negedge monitor checks every presented result,
// pulse width, latency, ready timing, held outputs and BCD digit legality.
module tb_bin_to_bcd_converter;

  localparam int MAXV = 9999;
  localparam int LAT  = 16;

  logic        clk;
  logic        rst;
  logic        dvalid;
  logic [15:0] din;
  logic        ready;
  logic [15:0] bcd;
  logic        bvalid;
  logic        ovf;

  bin_to_bcd_converter #(.MAX_VALUE(MAXV)) dut (
    .clk_in(clk), .rst_in(rst), .distance_valid_in(dvalid), .distance_in(din),
    .ready_out(ready), .bcd_out(bcd), .bcd_valid_out(bvalid), .overflow_out(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          busy_end = -100;
  int          acc_count = 0;
  bit          started = 0;
  bit          prev_valid = 0;
  logic [15:0] held = 16'h0;
  logic        held_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    int   s;
    s     = (v > MAXV) ? MAXV : v;
    e.ovf = (v > MAXV);
    e.bcd = 16'((s / 1000) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    e.acc = acc;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      for (int k = 0; k < 4; k++) check("nibble_le9", int'(bcd[k*4 +: 4] <= 4'd9), 1);
      check("ready_out", int'(ready), int'(cyc > busy_end));
      if (bvalid) begin
        check("pulse_width", int'(prev_valid), 0);
        if (sbq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("bcd_out", int'(bcd), int'(e.bcd));
          check("overflow_out", int'(ovf), int'(e.ovf));
          check("latency", cyc - e.acc, LAT);
          held     = e.bcd;
          held_ovf = e.ovf;
        end
      end else begin
        check("bcd_hold", int'(bcd), int'(held));
        check("ovf_hold", int'(ovf), int'(held_ovf));
        if (sbq.size() > 0 && cyc > sbq[0].acc + LAT) begin
          check("result_timeout", 0, 1);
          void'(sbq.pop_front());
        end
      end
      prev_valid = bvalid;
    end
    if (rst) begin
      started    = 1;
      sbq.delete();
      held       = 16'h0;
      held_ovf   = 1'b0;
      busy_end   = cyc;
      prev_valid = 0;
    end else if (started && dvalid && cyc > busy_end) begin
      sbq.push_back(model(int'(din), cyc + 1));
      busy_end = cyc + 1 + LAT;
      acc_count++;
    end
  end

  task automatic wait_accept();
    int c0, n;
    c0 = acc_count;
    n  = 0;
    while (acc_count == c0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_count == c0) check("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] v);
    dvalid = 1'b1;
    din    = v;
    wait_accept();
    dvalid = 1'b0;
  endtask

  task automatic wait_idle(input bit scramble);
    int n;
    n = 0;
    while ((sbq.size() != 0 || cyc <= busy_end) && n < 100) begin
      @(posedge clk); #1;
      if (scramble) din = 16'($urandom);
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] v;
    rst    = 1'b1;
    dvalid = 1'b1;
    din    = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    dvalid = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_bcd", int'(bcd), 0);
    check("rst_valid", int'(bvalid), 0);
    check("rst_ovf", int'(ovf), 0);
    @(posedge clk); #1;

    // Directed values including saturation boundaries.
    send(16'd0);     wait_idle(1'b1);
    send(16'd1234);  wait_idle(1'b1);
    send(16'd9999);  wait_idle(1'b1);
    send(16'd10000); wait_idle(1'b1);
    send(16'hFFFF);  wait_idle(1'b1);
    send(16'd42);    wait_idle(1'b1);

    // Valid held high through the conversion: second value waits for ready.
    dvalid = 1'b1;
    din    = 16'd57;
    wait_accept();
    din    = 16'd800;
    wait_accept();
    dvalid = 1'b0;
    wait_idle(1'b0);

    // Reset in the 8th SHIFT cycle aborts the conversion.
    send(16'd321);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_bcd", int'(bcd), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_valid", int'(bvalid), 0);
    @(posedge clk); #1;
    send(16'd5); wait_idle(1'b1);

    // Random sweep with random idle gaps and input churn while busy.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 9999));
        1:       v = 16'($urandom_range(9990, 10010));
        default: v = 16'($urandom);
      endcase
      send(v);
      wait_idle(1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Back-to-back with valid always high.
    dvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 16'($urandom);
      wait_accept();
    end
    dvalid = 1'b0;
    wait_idle(1'b0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
